buffer_reader: RTL and testbench

- Read-side drain engine for a pointer-based circular buffer whose push/pop bookkeeping lives in the buffer's controller.
- Issues pop requests on rd_dout and addresses the buffer storage, which has 1-cycle registered read latency.
- Captures returned words and presents them downstream on a valid/ready interface.
- Has a 2-entry output skid stage, so back-to-back pops sustain 1 word/cycle while out_ready stays high.

---
 rtl/buffer_reader.sv | 107 ++++++++++
 tb/tb_buffer_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: pops a circular buffer, absorbs the 1-cycle storage read latency and
// presents words through a 2-entry skid stage. Define BUFFER_READER_STALLCNT_EN for stall_cnt.
module buffer_reader #(
    parameter int ADDR_BW = 1,
    parameter int DATA_BW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [ADDR_BW-1:0] rd_ptr,
    output logic               rd_dout,
    output logic [ADDR_BW-1:0] mem_rdaddr,
    output logic               mem_rden,
    input  logic [DATA_BW-1:0] mem_rddata,
    input  logic               flush,
`ifdef BUFFER_READER_STALLCNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               out_valid,
    output logic [DATA_BW-1:0] out_data,
    input  logic               out_ready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] TWO  = 2'd2;

    logic [1:0]         r_state;
    logic               r_inflight;
    logic [DATA_BW-1:0] r_head;
    logic [DATA_BW-1:0] r_tail;

    logic       w_accept;
    logic       w_capture;
    logic       w_pop;
    logic [2:0] w_occ;

    assign w_accept  = out_valid & out_ready;
    assign w_capture = r_inflight;
    assign w_occ     = {1'b0, r_state} + {2'b00, r_inflight};

    // A word leaving this cycle frees a slot, so a full stage keeps popping while draining.
    assign w_pop      = ~rst & ~empty & ~flush & (w_occ < (3'd2 + {2'b00, w_accept}));
    assign rd_dout    = w_pop;
    assign mem_rden   = w_pop;
    assign mem_rdaddr = rst ? '0 : rd_ptr;
    assign out_valid  = (r_state == ONE) || (r_state == TWO);
    assign out_data   = r_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_pop;
            case (r_state)
                IDLE: if (w_capture) r_state <= ONE;
                ONE: begin
                    if (w_capture && !w_accept)      r_state <= TWO;
                    else if (!w_capture && w_accept) r_state <= IDLE;
                end
                TWO: if (w_accept) r_state <= ONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the skid entries are reset as well, because out_data must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush) begin
            case (r_state)
                IDLE: if (w_capture) r_head <= mem_rddata;
                ONE: begin
                    if (w_capture && w_accept) r_head <= mem_rddata;
                    else if (w_capture)        r_tail <= mem_rddata;
                end
                TWO: if (w_accept) r_head <= r_tail;
                default: ;
            endcase
        end
    end

`ifdef BUFFER_READER_STALLCNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    a_no_capture_in_two: assert property (@(posedge clk) disable iff (rst)
        !((r_state == TWO) && r_inflight));

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: buffer controller + registered storage model, directed
// scenarios and a randomized run, all checked through a popped-word scoreboard.
`timescale 1ns/1ps
module tb_buffer_reader;
    localparam int ADDR_BW = 2;
    localparam int DATA_BW = 8;
    localparam int DEPTH   = 1 << ADDR_BW;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic               empty     = 1'b1;
    logic               flush     = 1'b0;
    logic               out_ready = 1'b0;
    logic [ADDR_BW-1:0] rd_ptr    = '0;
    logic [DATA_BW-1:0] mem_rddata = '0;
    logic               rd_dout;
    logic               mem_rden;
    logic               out_valid;
    logic [ADDR_BW-1:0] mem_rdaddr;
    logic [DATA_BW-1:0] out_data;
`ifdef BUFFER_READER_STALLCNT_EN
    logic [15:0]        stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Environment state: storage, write side and scoreboard queues.
    logic [DATA_BW-1:0] mem [DEPTH];
    logic [ADDR_BW-1:0] wr_ptr = '0;
    int                 count  = 0;
    logic [DATA_BW-1:0] wr_q[$];
    logic [DATA_BW-1:0] sb_buf[$];
    logic [DATA_BW-1:0] sb_out[$];
    logic [DATA_BW-1:0] w_word;

    logic               lat_pop   = 1'b0;
    logic               lat_rden  = 1'b0;
    logic               lat_flush = 1'b0;
    logic [ADDR_BW-1:0] lat_addr  = '0;
    int                 rst_cnt   = 0;
    int                 env_rst_seen = 0;
    int                 mon_rst_seen = 0;
    logic               prev_hold = 1'b0;
    logic [DATA_BW-1:0] prev_data = '0;
    int                 delivered = 0;

    buffer_reader #(.ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW)) dut (
        .clk(clk), .rst(rst), .empty(empty), .rd_ptr(rd_ptr), .rd_dout(rd_dout),
        .mem_rdaddr(mem_rdaddr), .mem_rden(mem_rden), .mem_rddata(mem_rddata),
        .flush(flush),
`ifdef BUFFER_READER_STALLCNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DATA_BW-1:0] w);
        wr_q.push_back(w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Buffer controller and storage: act on what the DUT presented before the edge.
    always @(posedge clk) begin
        #2;
        if (lat_flush || (rst_cnt != env_rst_seen)) sb_out.delete();
        env_rst_seen = rst_cnt;
        if (lat_rden) mem_rddata = mem[lat_addr];
        if (lat_pop) begin
            rd_ptr = rd_ptr + 1'b1;
            count--;
            if (sb_buf.size() > 0) sb_out.push_back(sb_buf.pop_front());
        end
        while (wr_q.size() > 0 && count < DEPTH) begin
            w_word = wr_q.pop_front();
            mem[wr_ptr] = w_word;
            sb_buf.push_back(w_word);
            wr_ptr = wr_ptr + 1'b1;
            count++;
        end
        empty = (count == 0);
    end

    // Monitor: protocol rules and in-order delivery of every popped, non-discarded word.
    always @(negedge clk) begin
        lat_pop   = rd_dout;
        lat_rden  = mem_rden;
        lat_addr  = mem_rdaddr;
        lat_flush = flush;
        if (!rst) begin
            check("rden_eq_pop", mem_rden, rd_dout);
            if (rd_dout) begin
                check("pop_when_nonempty", empty, 1'b0);
                check("rdaddr_eq_rdptr", mem_rdaddr, rd_ptr);
            end
            if (flush) check("no_pop_in_flush", rd_dout, 1'b0);
            check("occupancy_le2", sb_out.size() <= 2, 1'b1);
            if (prev_hold && (mon_rst_seen == rst_cnt)) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready && !flush) begin
                if (sb_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", out_data);
                end else begin
                    check("out_data_order", out_data, sb_out.pop_front());
                end
                delivered++;
            end
        end
        prev_hold    = out_valid & ~out_ready & ~flush;
        prev_data    = out_data;
        mon_rst_seen = rst_cnt;
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        flush     = 1'b0;
        while ((wr_q.size() != 0 || sb_buf.size() != 0 || sb_out.size() != 0 || out_valid)
               && n < 300) begin
            step();
            n++;
        end
        check({name, "_drained"}, n < 300, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int pops;

        step();
        @(negedge clk);
        check("rst_rd_dout", rd_dout, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        step();
        rst = 1'b0;

        // Single word latency.
        out_ready = 1'b1;
        step();
        push(8'hA5);
        @(negedge clk);
        check("t1_pop_c0", rd_dout, 1'b1);
        check("t1_addr_c0", mem_rdaddr, rd_ptr);
        check("t1_valid_c0", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("t1_valid_c1", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("t1_valid_c2", out_valid, 1'b1);
        check("t1_data_c2", out_data, 8'hA5);
        step();
        @(negedge clk);
        check("t1_valid_c3", out_valid, 1'b0);

        // Streaming at full rate.
        step();
        for (int i = 1; i <= 4; i++) push(DATA_BW'(i));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("t2_pop_c%0d", c), rd_dout, c < 4);
            check($sformatf("t2_valid_c%0d", c), out_valid, (c >= 2) && (c <= 5));
            if (c >= 2 && c <= 5) check($sformatf("t2_data_c%0d", c), out_data, c - 1);
            step();
        end

        // Backpressure: two pops fill the skid stage, then the head holds.
        out_ready = 1'b0;
        d0 = delivered;
        pops = 0;
        step();
        for (int i = 0; i < 4; i++) push(8'h11 + DATA_BW'(i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_dout) pops++;
            if (c >= 2) begin
                check($sformatf("t3_valid_c%0d", c), out_valid, 1'b1);
                check($sformatf("t3_head_c%0d", c), out_data, 8'h11);
            end
            step();
        end
        check("t3_pop_count", pops, 2);
        drain("t3");
        check("t3_delivered", delivered - d0, 4);

        // Flush on the capture cycle in ONE, together with an accept.
        out_ready = 1'b0;
        step();
        push(8'h51);
        push(8'h52);
        push(8'h3C);
        step();
        step();
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("t4_valid_c2", out_valid, 1'b1);
        check("t4_no_pop_c2", rd_dout, 1'b0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t4_valid_c3", out_valid, 1'b0);
        check("t4_pop_c3", rd_dout, 1'b1);
        step();
        step();
        @(negedge clk);
        check("t4_valid_c5", out_valid, 1'b1);
        check("t4_data_c5", out_data, 8'h3C);
        drain("t4");

        // Asynchronous reset while two words are held.
        out_ready = 1'b0;
        d0 = delivered;
        step();
        for (int i = 0; i < 4; i++) push(8'hA1 + DATA_BW'(i));
        repeat (3) step();
        @(negedge clk);
        check("t5_pre_valid", out_valid, 1'b1);
        step();
        #2;
        rst = 1'b1;
        rst_cnt++;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_pop", rd_dout, 1'b0);
        check("t5_rst_data", out_data, 8'h00);
`ifdef BUFFER_READER_STALLCNT_EN
        check("t5_rst_stall", stall_cnt, 16'd0);
`endif
        rst = 1'b0;
        drain("t5");
        check("t5_delivered", delivered - d0, 2);

`ifdef BUFFER_READER_STALLCNT_EN
        // Stall counter: ten stalled cycles, then flush clears it.
        out_ready = 1'b0;
        step();
        push(8'h77);
        repeat (12) step();
        flush = 1'b1;
        @(negedge clk);
        check("t6_stall_10", stall_cnt, 16'd10);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t6_stall_flushed", stall_cnt, 16'd0);
        drain("t6");
`endif

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            if (wr_q.size() < 2 && $urandom_range(0, 2) != 0) push(DATA_BW'($urandom_range(0, 255)));
        end
        drain("rand");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
